// File: rtl/doorlock_ctrl.sv
// rtl/doorlock_ctrl.sv - door lock code entry, check and password-set sequencer
// Optional three-strike lockout is enabled by defining DOORLOCK_ALARM_EN.
module doorlock_ctrl #(
    parameter int          DIGITS        = 4,
    parameter logic [15:0] DEFAULT_PW    = 16'h1234,
    parameter logic [31:0] OPEN_CYCLES   = 32'd150_000_000,
    parameter logic [31:0] ENTRY_TIMEOUT = 32'd500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  sw_in,
    input  logic        key_in,
    input  logic        key_mode,
    output logic [9:0]  enc_data,
    input  logic [3:0]  enc_number,
    output logic [15:0] fnd_num,
    output logic        unlock,
    output logic        fail,
    output logic        err_key,
    output logic        alarm,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_CHECK = 3'd2,
        S_OPEN  = 3'd3,
        S_SET   = 3'd4,
        S_ALARM = 3'd5
    } state_t;

    localparam logic [15:0] PW_MASK = 16'hffff >> (16 - 4 * DIGITS);
    localparam logic [2:0]  LAST    = 3'(DIGITS);

    state_t      st;
    logic [15:0] code_buf;
    logic [15:0] password;
    logic [2:0]  count;
    logic [31:0] timer;
`ifdef DOORLOCK_ALARM_EN
    logic [1:0]  fail_cnt;
`endif

    logic        digit_ok;
    logic [15:0] buf_shift;
    logic [2:0]  count_inc;
    logic        last_digit;
    logic        match;

    assign digit_ok   = (enc_number <= 4'd9);
    assign buf_shift  = {code_buf[11:0], enc_number};
    assign count_inc  = count + 3'd1;
    assign last_digit = (count_inc == LAST);
    assign match      = ((code_buf ^ password) & PW_MASK) == 16'h0000;
    assign state      = st;
    assign enc_data   = (st == S_IDLE || st == S_ENTRY || st == S_SET) ? sw_in : 10'h000;

    // Entered digits sit right-aligned; positions not yet typed stay blank.
    function automatic logic [15:0] disp(input logic [15:0] b, input logic [2:0] n);
        logic [15:0] d;
        for (int i = 0; i < 4; i++)
            d[4*i +: 4] = (i < int'(n)) ? b[4*i +: 4] : 4'hf;
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            password <= DEFAULT_PW;
            code_buf <= '0;
            count    <= '0;
            timer    <= '0;
            unlock   <= 1'b0;
            fail     <= 1'b0;
            err_key  <= 1'b0;
            fnd_num  <= 16'hffff;
`ifdef DOORLOCK_ALARM_EN
            alarm    <= 1'b0;
            fail_cnt <= '0;
`endif
        end else begin
            fail    <= 1'b0;
            err_key <= 1'b0;
            case (st)
                S_IDLE, S_ENTRY, S_SET: begin
                    if (key_in) begin
                        timer <= '0;
                        if (!digit_ok) begin
                            err_key <= 1'b1;
                        end else if (last_digit && st == S_SET) begin
                            password <= buf_shift;
                            code_buf <= '0;
                            count    <= '0;
                            fnd_num  <= 16'hffff;
                            st       <= S_IDLE;
                        end else begin
                            code_buf <= buf_shift;
                            count    <= count_inc;
                            fnd_num  <= disp(buf_shift, count_inc);
                            st       <= last_digit ? S_CHECK : ((st == S_IDLE) ? S_ENTRY : st);
                        end
                    end else if (st != S_IDLE) begin
                        // Abandoned entry: drop the partial code, password untouched.
                        if (timer == ENTRY_TIMEOUT - 32'd1) begin
                            code_buf <= '0;
                            count    <= '0;
                            fnd_num  <= 16'hffff;
                            st       <= S_IDLE;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                end
                S_CHECK: begin
                    code_buf <= '0;
                    count    <= '0;
                    fnd_num  <= 16'hffff;
                    if (match) begin
                        st      <= S_OPEN;
                        unlock  <= 1'b1;
                        timer   <= '0;
                        fnd_num <= 16'h0feb;
`ifdef DOORLOCK_ALARM_EN
                        fail_cnt <= '0;
`endif
                    end else begin
                        fail <= 1'b1;
`ifdef DOORLOCK_ALARM_EN
                        if (fail_cnt == 2'd2) begin
                            st      <= S_ALARM;
                            alarm   <= 1'b1;
                            timer   <= '0;
                            fnd_num <= 16'haaaa;
                        end else begin
                            fail_cnt <= fail_cnt + 2'd1;
                            st       <= S_IDLE;
                        end
`else
                        st <= S_IDLE;
`endif
                    end
                end
                S_OPEN: begin
                    if (key_mode) begin
                        st      <= S_SET;
                        unlock  <= 1'b0;
                        timer   <= '0;
                        fnd_num <= 16'hffff;
                    end else if (timer == OPEN_CYCLES - 32'd1) begin
                        st      <= S_IDLE;
                        unlock  <= 1'b0;
                        fnd_num <= 16'hffff;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
`ifdef DOORLOCK_ALARM_EN
                S_ALARM: begin
                    if (timer == OPEN_CYCLES - 32'd1) begin
                        st       <= S_IDLE;
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                        fnd_num  <= 16'hffff;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
`endif
                default: st <= S_IDLE;
            endcase
        end
    end

`ifndef DOORLOCK_ALARM_EN
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb/tb_doorlock_ctrl.sv - randomized scoreboard bench for doorlock_ctrl
`timescale 1ns/1ps
module tb_doorlock_ctrl;
    localparam int OC = 20;
    localparam int TO = 30;
`ifdef DOORLOCK_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif
    localparam int M_LOCK = 0, M_OPEN = 1, M_SET = 2, M_ALARM = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sw_in = 10'h000;
    logic        key_in = 1'b0;
    logic        key_mode = 1'b0;
    logic [9:0]  enc_data;
    logic [3:0]  enc_number;
    logic [15:0] fnd_num;
    logic        unlock, fail, err_key, alarm;
    logic [2:0]  state;

    doorlock_ctrl #(
        .DIGITS(4), .DEFAULT_PW(16'h1234),
        .OPEN_CYCLES(32'(OC)), .ENTRY_TIMEOUT(32'(TO))
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .key_in(key_in), .key_mode(key_mode),
        .enc_data(enc_data), .enc_number(enc_number), .fnd_num(fnd_num),
        .unlock(unlock), .fail(fail), .err_key(err_key), .alarm(alarm), .state(state)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-hot switch-to-digit encoder
    always_comb begin
        enc_number = 4'he;
        if ($countones(enc_data) == 1)
            for (int i = 0; i < 10; i++)
                if (enc_data[i]) enc_number = 4'(i);
    end

    typedef struct packed { logic [3:0] flags; logic [15:0] d; } outs_t; // flags = unlock,fail,err_key,alarm
    typedef struct { int c; outs_t o; } exp_t;
    localparam outs_t RST_OUTS = 20'h0ffff;

    exp_t        sb[$];
    outs_t       last_exp;
    int          checks = 0, failures = 0;
    logic        mon_en = 1'b0;

    int          q[$];
    logic [15:0] pw;
    int          fails, mode, last_key, open_end, alarm_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] shown();
        logic [15:0] d = 16'hffff;
        for (int i = 0; i < q.size(); i++) d[4*i +: 4] = 4'(q[q.size() - 1 - i]);
        return d;
    endfunction

    task automatic push(input int c, input logic [3:0] fl, input logic [15:0] d);
        exp_t x;
        x.c = c;
        x.o = {fl, d};
        if (x.o != last_exp) begin
            sb.push_back(x);
            last_exp = x.o;
        end
    endtask

    task automatic model_key(input logic [9:0] s, input int k);
        int d;
        logic [15:0] code;
        if (mode == M_OPEN || mode == M_ALARM) return;
        last_key = k;
        if ($countones(s) != 1) begin
            push(k, 4'b0010, shown());
            push(k + 1, 4'b0000, shown());
            return;
        end
        d = 0;
        for (int i = 0; i < 10; i++) if (s[i]) d = i;
        q.push_back(d);
        if (q.size() < 4) begin
            push(k, 4'b0000, shown());
            return;
        end
        code = 16'h0;
        for (int i = 0; i < 4; i++) code = {code[11:0], 4'(q[i])};
        if (mode == M_SET) begin
            pw = code;
            q.delete();
            mode = M_LOCK;
            push(k, 4'b0000, 16'hffff);
            return;
        end
        push(k, 4'b0000, shown());
        q.delete();
        if (code == pw) begin
            fails = 0;
            mode = M_OPEN;
            open_end = k + 1 + OC;
            push(k + 1, 4'b1000, 16'h0feb);
        end else begin
            fails++;
            if (ALARM_EN && fails == 3) begin
                fails = 0;
                mode = M_ALARM;
                alarm_end = k + 1 + OC;
                push(k + 1, 4'b0101, 16'haaaa);
                push(k + 2, 4'b0001, 16'haaaa);
                push(alarm_end, 4'b0000, 16'hffff);
            end else begin
                push(k + 1, 4'b0100, 16'hffff);
                push(k + 2, 4'b0000, 16'hffff);
            end
        end
    endtask

    task automatic model_mode(input int k);
        if (mode != M_OPEN) return;
        mode = M_SET;
        last_key = k;
        push(k, 4'b0000, 16'hffff);
    endtask

    task automatic press(input logic [9:0] s, input logic with_mode);
        int k;
        @(negedge clk);
        sw_in = s; key_in = 1'b1; key_mode = with_mode; k = cyc + 1;
        if (with_mode && mode == M_OPEN) model_mode(k);
        else model_key(s, k);
        @(negedge clk);
        key_in = 1'b0; key_mode = 1'b0;
    endtask

    task automatic press_mode();
        int k;
        @(negedge clk);
        key_mode = 1'b1; k = cyc + 1;
        model_mode(k);
        @(negedge clk);
        key_mode = 1'b0;
    endtask

    task automatic digit(input int d);
        logic [9:0] s;
        s = 10'b1 << d;
        press(s, 1'b0);
    endtask

    function automatic logic [9:0] rand_bad();
        logic [9:0] s;
        do s = 10'($urandom); while ($countones(s) == 1);
        return s;
    endfunction

    function automatic logic [15:0] rand_code();
        logic [15:0] c;
        for (int i = 0; i < 4; i++) c[4*i +: 4] = 4'($urandom_range(0, 9));
        return c;
    endfunction

    task automatic enter(input logic [15:0] code, input bit noisy);
        for (int i = 3; i >= 0; i--) begin
            if (noisy && $urandom_range(0, 2) == 0) press(rand_bad(), 1'b0);
            digit(int'(code[4*i +: 4]));
        end
    endtask

    // Advances time, settling any spec-defined timed transition the model knows is due.
    task automatic wait_cycles(input int n);
        int t;
        t = cyc + n;
        if (mode == M_OPEN && open_end <= t) begin
            push(open_end, 4'b0000, 16'hffff);
            mode = M_LOCK;
        end
        if (mode == M_ALARM && alarm_end <= t) mode = M_LOCK;
        if ((mode == M_SET || q.size() > 0) && last_key + TO <= t) begin
            push(last_key + TO, 4'b0000, 16'hffff);
            q.delete();
            mode = M_LOCK;
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic try_code(input logic [15:0] code, input bit noisy);
        enter(code, noisy);
        wait_cycles(3);
        if (mode == M_ALARM) begin
            chk("alarm_fnd", 32'(fnd_num), 32'h0000aaaa);
            digit(3);
            press(10'h010, 1'b1);
            digit(4);
            wait_cycles(alarm_end - cyc + 2);
        end
    endtask

    task automatic do_reset();
        int r;
        @(negedge clk);
        rst = 1'b1; r = cyc + 1;
        push(r, 4'b0000, 16'hffff);
        q.delete(); pw = 16'h1234; fails = 0; mode = M_LOCK;
        @(negedge clk);
        chk("rst_unlock", 32'(unlock), 32'd0);
        chk("rst_fnd", 32'(fnd_num), 32'h0000ffff);
        chk("rst_state", 32'(state), 32'd0);
        rst = 1'b0;
    endtask

    initial begin : monitor
        outs_t cur, prev;
        exp_t  x;
        prev = RST_OUTS;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {unlock, fail, err_key, alarm, fnd_num};
                if (cur !== prev) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output cyc=%0d actual=%h expected=no change", cyc, cur);
                    end else begin
                        x = sb.pop_front();
                        if (x.c != cyc || x.o !== cur) begin
                            failures++;
                            $display("FAIL output_event actual cyc=%0d ufea_fnd=%h expected cyc=%0d ufea_fnd=%h",
                                     cyc, cur, x.c, x.o);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] code;
        pw = 16'h1234; mode = M_LOCK; fails = 0; last_key = 0; last_exp = RST_OUTS;
        repeat (3) @(negedge clk);
        chk("reset_unlock", 32'(unlock), 32'd0);
        chk("reset_fail", 32'(fail), 32'd0);
        chk("reset_err_key", 32'(err_key), 32'd0);
        chk("reset_alarm", 32'(alarm), 32'd0);
        chk("reset_fnd", 32'(fnd_num), 32'h0000ffff);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_enc_data", 32'(enc_data), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        try_code(16'h1234, 1'b0);
        chk("open_state", 32'(state), 32'd3);
        sw_in = 10'h3ff; #1;
        chk("open_enc_data", 32'(enc_data), 32'd0);
        digit(5);
        wait_cycles(OC);
        chk("closed_state", 32'(state), 32'd0);
        sw_in = 10'h155; #1;
        chk("idle_enc_data", 32'(enc_data), 32'h155);

        try_code(16'h1235, 1'b0);
        digit(1); press(10'h003, 1'b0); press(10'h000, 1'b0); digit(7);
        digit(2); digit(9);
        wait_cycles(3);
        press_mode();
        try_code(16'h1234, 1'b1);
        wait_cycles(OC);

        repeat (4) begin
            do code = rand_code(); while (code == pw);
            try_code(code, 1'b1);
        end
        try_code(pw, 1'b1);
        wait_cycles(OC);

        try_code(pw, 1'b0);
        press_mode();
        enter(16'h9876, 1'b0);
        wait_cycles(2);
        try_code(16'h1234, 1'b0);
        try_code(16'h9876, 1'b0);
        wait_cycles(OC);

        code = rand_code();
        try_code(pw, 1'b0);
        press(10'h004, 1'b1);
        enter(code, 1'b1);
        wait_cycles(2);
        press(10'b1 << code[15:12], 1'b1);
        for (int i = 2; i >= 0; i--) digit(int'(code[4*i +: 4]));
        wait_cycles(3);
        wait_cycles(OC);

        try_code(pw, 1'b0);
        press_mode();
        digit(6); digit(1);
        wait_cycles(TO + 3);
        try_code(pw, 1'b0);
        wait_cycles(OC);

        digit(4); digit(2);
        wait_cycles(TO + 3);
        chk("timeout_state", 32'(state), 32'd0);
        chk("timeout_fnd", 32'(fnd_num), 32'h0000ffff);

        try_code(pw, 1'b0);
        wait_cycles(OC);
        for (int n = 0; n < 3; n++) begin
            do code = rand_code(); while (code == pw);
            try_code(code, 1'b0);
        end

        digit(8); digit(3);
        do_reset();

        try_code(16'h1234, 1'b0);
        press_mode();
        digit(5); digit(5);
        do_reset();
        try_code(16'h1234, 1'b0);
        wait_cycles(OC + 2);

        wait_cycles(5);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
